ebus_diag_seq: RTL and testbench
================================

// Module: ebus_diag_seq
// PURPOSE
//  Front-end diagnostic request sequencer sitting between the DTE request source and EBUS.
//  Queues front-end requests (diag function / diag read / diag write / misc) and runs each
//  as a timed EBUS diagnostic cycle: DS setup, DIAG STROBE pulse, data settle, sample.
//  Returns one response per request, carrying sampled EBUS data. Decodes misc CLR CROBAR.
// PARAMETERS
//  DEPTH          8   request FIFO entries (power of 2, >=2)
//  STROBE_CYCLES  2   clocks DIAG STROBE held high (>=1)
//  SETTLE_CYCLES  3   clocks after strobe drop before EBUS data sampled (>=1)
// PORTS
//  EBUS_CLK        in   1   EBUS clock; the only clock
//  RESET           in   1   synchronous, active-high reset (not CROBAR)
//  req_valid       in   1   request offered
//  req_ready       out  1   FIFO can accept; push = req_valid & req_ready
//  req_type        in   2   tFEReqType
//  req_func        in   7   diag function code / misc function code
//  req_data        in   36  write data, bits [0:35], bit 0 = MSB
//  ebus_ds         out  7   EBUS diag select
//  ebus_diag_strobe out 1   EBUS DIAG STROBE
//  ebus_drive      out  1   this block drives EBUS data (diag write only)
//  ebus_data_out   out  36  EBUS drive data [0:35]
//  ebus_data_in    in   36  EBUS data bus [0:35]
//  rsp_valid       out  1   response available; held until rsp_ready
//  rsp_ready       in   1   response accepted; pop = rsp_valid & rsp_ready
//  rsp_type        out  2   echoed req_type
//  rsp_func        out  7   echoed req_func
//  rsp_data        out  36  sampled EBUS data; 0 for misc
//  clr_crobar      out  1   one-clock pulse, drives CROBAR clear
//  busy            out  1   FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (RESET=1 at clock edge): FIFO flushed, FSM->IDLE, all outputs 0 except req_ready=1.
//   In-flight transaction dropped, no response. Reset wins over simultaneous push/pop.
//  FIFO: rd/wr pointers wrap at DEPTH; count 0..DEPTH. req_ready = (count != DEPTH); no
//   bypass: when full, a same-cycle pop does not enable a push. Pop only in IDLE.
//  FSM states: IDLE, SETUP, STROBE, SETTLE, MISC, RESP.
//   IDLE: FIFO non-empty -> pop head into working reg; misc -> MISC, else -> SETUP.
//   SETUP (1 clk): ebus_ds=func; if DIAG_WRITE ebus_drive=1, ebus_data_out=req_data.
//   STROBE (STROBE_CYCLES clks): ebus_diag_strobe=1; ds/drive/data held.
//   SETTLE (SETTLE_CYCLES clks): strobe 0, ds/drive/data held; on last clk capture
//    ebus_data_in into rsp_data (all bus types, write included) -> RESP.
//   MISC (1 clk): func==0 (clrCROBAR) -> clr_crobar=1 this clk; other codes no action;
//    rsp_data=0 -> RESP.
//   RESP: rsp_valid=1, ebus_drive=0, ebus_ds held; on rsp_ready -> IDLE.
//  Latency pop->rsp_valid: bus op 1+STROBE_CYCLES+SETTLE_CYCLES+1 clks; misc 2 clks.
//  ebus_drive never 1 outside SETUP/STROBE/SETTLE of a DIAG_WRITE; ebus_data_out=0 when not driving.
//  Back-to-back requests: at least one IDLE clock between transactions (strobe gap).
//  Response order = request order; exactly one response per accepted request.
// STRUCTURE
//  dte_pkg: tFEReqType {DIAG_FUNC=0,DIAG_READ=1,DIAG_WRITE=2,MISC=3} (2-bit),
//   tMiscFuncType {CLR_CROBAR=0}, tDiagReq struct {type,func[7],data[0:35]}, tSeqState enum.
//  Sub-module diag_req_fifo (DEPTH x tDiagReq, sync reset, full/empty/count).
//  Top: FSM + cycle counter ($clog2 of max(STROBE,SETTLE)+1 bits) + working/response regs.
// TESTING
//  1 DIAG_READ func=7'o14, ebus_data_in=36'o123456_701234, rsp_ready=1 -> ds=14 during
//    SETUP..SETTLE, strobe high exactly 2 clks, rsp_data=123456701234, rsp_valid 7 clks after pop.
//  2 DIAG_WRITE func=7'o71 data=36'o777000_000777 -> ebus_drive=1 for 6 clks, data_out matches,
//    drive=0 in RESP; rsp_type=DIAG_WRITE.
//  3 MISC func=0 -> clr_crobar single 1-clk pulse, no strobe, rsp_data=0, rsp_valid 2 clks after pop.
//  4 Push 9 requests with rsp_ready=0 -> req_ready drops at count=8 (1 in FSM holding RESP),
//    no push lost; release rsp_ready -> 9 responses in order.
//  5 Full FIFO + pop same clk + req_valid -> push refused that clk, accepted next clk.
//  6 Assert RESET during STROBE -> next clk strobe=0, drive=0, rsp_valid=0, FIFO empty,
//    busy=0, no response ever emitted for dropped request.

Source files
------------

// File: rtl/ebus_diag_seq_pkg.sv
// ebus_diag_seq_pkg: request types, request record and sequencer states for the EBUS diag sequencer
package ebus_diag_seq_pkg;
  typedef enum logic [1:0] {DIAG_FUNC = 2'd0, DIAG_READ = 2'd1, DIAG_WRITE = 2'd2, MISC = 2'd3} fe_req_type_e;
  typedef enum logic [6:0] {CLR_CROBAR = 7'd0} misc_func_e;
  typedef struct packed {
    fe_req_type_e rtype;
    logic [6:0]   func;
    logic [0:35]  data;
  } diag_req_t;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_SETTLE, S_MISC, S_RESP} seq_state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ebus_diag_seq_if.sv
// ebus_diag_seq_if: request, EBUS diagnostic and response signals of the sequencer
interface ebus_diag_seq_if;
  import ebus_diag_seq_pkg::*;
  logic         req_valid;
  logic         req_ready;
  fe_req_type_e req_type;
  logic [6:0]   req_func;
  logic [0:35]  req_data;
  logic [6:0]   ebus_ds;
  logic         ebus_diag_strobe;
  logic         ebus_drive;
  logic [0:35]  ebus_data_out;
  logic [0:35]  ebus_data_in;
  logic         rsp_valid;
  logic         rsp_ready;
  fe_req_type_e rsp_type;
  logic [6:0]   rsp_func;
  logic [0:35]  rsp_data;
  logic         clr_crobar;
  logic         busy;
  modport slave (
    input  req_valid, req_type, req_func, req_data, ebus_data_in, rsp_ready,
    output req_ready, ebus_ds, ebus_diag_strobe, ebus_drive, ebus_data_out,
           rsp_valid, rsp_type, rsp_func, rsp_data, clr_crobar, busy
  );
  modport master (
    output req_valid, req_type, req_func, req_data, ebus_data_in, rsp_ready,
    input  req_ready, ebus_ds, ebus_diag_strobe, ebus_drive, ebus_data_out,
           rsp_valid, rsp_type, rsp_func, rsp_data, clr_crobar, busy
  );
endinterface

// File: rtl/ebus_diag_seq_fifo.sv
// ebus_diag_seq_fifo: DEPTH-entry request FIFO with sync reset and full/empty/count
module ebus_diag_seq_fifo import ebus_diag_seq_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  diag_req_t              din_i,
  output diag_req_t              dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  diag_req_t     mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  // storage: entries are only read behind a non-zero count, so no reset
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ebus_diag_seq.sv
// ebus_diag_seq: queues front-end requests and runs each as a timed EBUS diagnostic cycle
module ebus_diag_seq import ebus_diag_seq_pkg::*; #(
  parameter int DEPTH         = 8,
  parameter int STROBE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input logic           EBUS_CLK,
  input logic           RESET,
  ebus_diag_seq_if.slave bus
);
  localparam int CW = $clog2(max_int(STROBE_CYCLES, SETTLE_CYCLES) + 1);
  seq_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  diag_req_t             work_q, work_d, head, req_in;
  logic [6:0]            ds_q, ds_d;
  logic [0:35]           rsp_data_q, rsp_data_d;
  logic                  full, empty, pop, bus_phase, drive;
  logic [$clog2(DEPTH):0] count;
  assign req_in = '{rtype: bus.req_type, func: bus.req_func, data: bus.req_data};
  ebus_diag_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (EBUS_CLK),
    .rst     (RESET),
    .push_i  (bus.req_valid & ~full),
    .pop_i   (pop),
    .din_i   (req_in),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // sequencer next state: one diag cycle per popped request, pop only from IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    ds_d       = ds_q;
    rsp_data_d = rsp_data_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE:
        if (!empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = head.rtype == MISC ? S_MISC : S_SETUP;
          ds_d    = head.rtype == MISC ? ds_q : head.func;
        end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = '0;
      end
      S_STROBE:
        if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      S_SETTLE:
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_d    = S_RESP;
          rsp_data_d = bus.ebus_data_in;
        end else cnt_d = cnt_q + CW'(1);
      S_MISC: begin
        state_d    = S_RESP;
        rsp_data_d = '0;
      end
      S_RESP: state_d = bus.rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  // state and working registers; reset drops any in-flight request
  always_ff @(posedge EBUS_CLK)
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      ds_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      ds_q       <= ds_d;
      rsp_data_q <= rsp_data_d;
    end
  assign bus_phase            = state_q inside {S_SETUP, S_STROBE, S_SETTLE};
  assign drive                = bus_phase && work_q.rtype == DIAG_WRITE;
  assign bus.req_ready        = ~full;
  assign bus.ebus_ds          = ds_q;
  assign bus.ebus_diag_strobe = state_q == S_STROBE;
  assign bus.ebus_drive       = drive;
  assign bus.ebus_data_out    = drive ? work_q.data : '0;
  assign bus.rsp_valid        = state_q == S_RESP;
  assign bus.rsp_type         = work_q.rtype;
  assign bus.rsp_func         = work_q.func;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.clr_crobar       = state_q == S_MISC && work_q.func == CLR_CROBAR;
  assign bus.busy             = state_q != S_IDLE || count != '0;
endmodule

// File: tb/tb_ebus_diag_seq.sv
// tb_ebus_diag_seq: table, directed and randomized checks of the EBUS diagnostic sequencer
module tb_ebus_diag_seq;
  import ebus_diag_seq_pkg::*;
  typedef struct {
    logic [1:0]  t;
    logic [6:0]  f;
    logic [35:0] d;
    logic [35:0] bin;
    logic [35:0] rd;
    int          lat;
    int          ns;
    int          nd;
    int          nc;
  } vec_t;
  typedef struct {
    logic [1:0] t;
    logic [6:0] f;
  } req_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        echo = 1'b0;
  logic [35:0] bus_in_fix = '0;
  int          checks = 0;
  int          errors = 0;
  req_t        sb[$];
  vec_t        tbl[5];
  ebus_diag_seq_if bus();
  ebus_diag_seq dut (.EBUS_CLK(clk), .RESET(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [35:0] pat(input logic [6:0] f);
    return {f, ~f, f, ~f, f, 1'b1};
  endfunction
  always_comb bus.ebus_data_in = echo ? pat(bus.ebus_ds) : bus_in_fix;
  function automatic logic [63:0] exp_rsp(input req_t r);
    return {19'd0, r.t, r.f, r.t == 2'd3 ? 36'd0 : pat(r.f)};
  endfunction
  function automatic logic [63:0] rsp_word();
    return {19'd0, bus.rsp_type, bus.rsp_func, bus.rsp_data};
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic push_req(input logic [1:0] t, input logic [6:0] f, input logic [35:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_type  = fe_req_type_e'(t);
    bus.req_func  = f;
    bus.req_data  = d;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 1, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic run_vec(input int k, input vec_t v);
    int e = 0, seen = -1, ns = 0, nd = 0, nc = 0, bad = 0;
    bus_in_fix = v.bin;
    push_req(v.t, v.f, v.d);
    while (seen < 0 && e < 40) begin
      if (bus.ebus_diag_strobe) ns++;
      if (bus.ebus_drive) nd++;
      if (bus.clr_crobar) nc++;
      if (bus.ebus_diag_strobe && bus.ebus_ds != v.f) bad++;
      if (bus.ebus_data_out != (bus.ebus_drive ? v.d : 36'd0)) bad++;
      if (bus.rsp_valid) seen = e;
      else begin
        @(negedge clk);
        e++;
      end
    end
    chk($sformatf("v%0d_latency", k), seen, v.lat);
    chk($sformatf("v%0d_strobe_clks", k), ns, v.ns);
    chk($sformatf("v%0d_drive_clks", k), nd, v.nd);
    chk($sformatf("v%0d_crobar_pulses", k), nc, v.nc);
    chk($sformatf("v%0d_ds_data_out", k), bad, 0);
    chk($sformatf("v%0d_rsp", k), rsp_word(), {19'd0, v.t, v.f, v.rd});
    chk($sformatf("v%0d_drive_in_resp", k), bus.ebus_drive, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_gone", k), bus.rsp_valid, 0);
    chk($sformatf("v%0d_idle", k), bus.busy, 0);
  endtask
  task automatic drain(input int budget);
    int n = 0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    while (sb.size() > 0 && n < budget) begin
      if (bus.rsp_valid) chk("rsp_order", rsp_word(), exp_rsp(sb.pop_front()));
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    bus.rsp_ready = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, hits, viol;
    bus.req_valid = 1'b0;
    bus.req_type  = DIAG_FUNC;
    bus.req_func  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    tbl[0] = '{2'd1, 7'o14, 36'd0, 36'o123456701234, 36'o123456701234, 7, 2, 0, 0};
    tbl[1] = '{2'd2, 7'o71, 36'o777000000777, 36'o252525252525, 36'o252525252525, 7, 2, 6, 0};
    tbl[2] = '{2'd3, 7'd0, 36'o111, 36'o777777777777, 36'd0, 2, 0, 0, 1};
    tbl[3] = '{2'd3, 7'd5, 36'd0, 36'o1234, 36'd0, 2, 0, 0, 0};
    tbl[4] = '{2'd0, 7'h7f, 36'd0, 36'hfffffffff, 36'hfffffffff, 7, 2, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_strobe", bus.ebus_diag_strobe, 0);
    chk("rst_drive", bus.ebus_drive, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_crobar", bus.clr_crobar, 0);
    chk("rst_ds", bus.ebus_ds, 0);
    chk("rst_data_out", bus.ebus_data_out, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    foreach (tbl[i]) run_vec(i, tbl[i]);
    bus_in_fix = 36'o5;
    push_req(2'd2, 7'o33, 36'o707070707070);
    push_req(2'd1, 7'o2, 36'd0);
    n = 0;
    while (!bus.ebus_diag_strobe && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_strobe_reached", bus.ebus_diag_strobe, 1);
    chk("t6_drive_in_strobe", bus.ebus_drive, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_strobe", bus.ebus_diag_strobe, 0);
    chk("t6_drive", bus.ebus_drive, 0);
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_req_ready", bus.req_ready, 1);
    chk("t6_ds", bus.ebus_ds, 0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_valid) hits++;
    end
    chk("t6_no_rsp", hits, 0);
    bus.rsp_ready = 1'b0;
    echo = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("t4_ready_before_9th", bus.req_ready, 1);
      push_req(2'(i % 4), 7'(i + 16), {$urandom, 4'h0});
      sb.push_back('{2'(i % 4), 7'(i + 16)});
    end
    chk("t4_full", bus.req_ready, 0);
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_type  = MISC;
    bus.req_func  = 7'd9;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    chk("t5_full_with_rsp", bus.req_ready, 0);
    chk("t5_rsp_valid", bus.rsp_valid, 1);
    chk("t5_first_rsp", rsp_word(), exp_rsp(sb.pop_front()));
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("t5_pop_clk_ready", bus.req_ready, 0);
    chk("t5_idle_clk", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t5_ready_next", bus.req_ready, 1);
    sb.push_back('{2'd3, 7'd9});
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain(400);
    repeat (3) @(negedge clk);
    chk("t4_busy_after_drain", bus.busy, 0);
    viol = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.req_valid = $urandom_range(0, 2) == 0;
      bus.req_type  = fe_req_type_e'($urandom_range(0, 3));
      bus.req_func  = $urandom_range(0, 3) == 0 ? 7'd0 : 7'($urandom);
      bus.req_data  = {$urandom, 4'($urandom)};
      bus.rsp_ready = $urandom_range(0, 1) == 1;
      if (bus.req_valid && bus.req_ready) sb.push_back('{bus.req_type, bus.req_func});
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) chk("rnd_extra_rsp", 1, 0);
        else chk("rnd_rsp", rsp_word(), exp_rsp(sb.pop_front()));
      end
      if (bus.ebus_drive && bus.rsp_valid) viol++;
      if (!bus.ebus_drive && bus.ebus_data_out != '0) viol++;
      if (bus.ebus_diag_strobe && bus.clr_crobar) viol++;
    end
    chk("rnd_invariants", viol, 0);
    drain(600);
    repeat (3) @(negedge clk);
    chk("rnd_busy_end", bus.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
